// File: rtl/epc_pkg.sv
// rtl/epc_pkg.sv - shared FSM type, error word, region-index field and bit-order helper for the EPC bus
package epc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} epc_state_e;

  localparam logic [31:0] EPC_ERR_WORD = 32'hDEADBEEF;
  localparam int REG_IDX_MSB = 15;
  localparam int REG_IDX_LSB = 8;
  localparam int REG_IDX_W   = REG_IDX_MSB - REG_IDX_LSB + 1;

  // EPC numbers bit 0 as the MSB; the numeric value is kept, only the index order flips
  function automatic logic [31:0] epc_to_le(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/epc_decode.sv
// rtl/epc_decode.sv - combinational EPC address decode to {valid, region index, one-hot select}
module epc_decode
  import epc_pkg::*;
#(
  parameter int N_REGION = 32
) (
  input  logic [31:REG_IDX_LSB] addr,
  output logic                  valid,
  output logic [REG_IDX_W-1:0]  idx,
  output logic [N_REGION-1:0]   onehot
);

  assign idx    = addr[REG_IDX_MSB:REG_IDX_LSB];
  assign valid  = (addr[31:REG_IDX_MSB+1] == '0) && (32'(idx) < N_REGION);
  assign onehot = valid ? (N_REGION'(1) << idx) : '0;

endmodule

// File: rtl/epc_bus_ctl.sv
// rtl/epc_bus_ctl.sv - EPC slave to shared register bus controller with address-error and ack-timeout handling
// Optional ack timeout in WAIT is enabled by defining EPC_BUS_CTL_TIMEOUT_EN.
module epc_bus_ctl
  import epc_pkg::*;
#(
  parameter int          N_REGION = 32,
  parameter int          TIMEOUT  = 8,
  parameter logic [31:0] ERR_WORD = EPC_ERR_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:31]           epc_addr,
  input  logic                  epc_ads,
  input  logic                  epc_cs_n,
  input  logic                  epc_rnw,
  input  logic [0:3]            epc_be,
  input  logic [0:31]           epc_wdata,
  output logic [0:31]           epc_rdata,
  output logic                  epc_rdy,
  output logic [5:0]            reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_be,
  output logic [N_REGION-1:0]   reg_wr_stb,
  output logic [N_REGION-1:0]   reg_rd_stb,
  input  logic [N_REGION*32-1:0] reg_rdata,
  input  logic [N_REGION-1:0]   reg_ack,
  output logic [15:0]           err_cnt
);

  epc_state_e             state;
  logic                   rnw_q;
  logic [REG_IDX_W-1:0]   idx_q;
  logic [N_REGION-1:0]    sel_q;
  logic [31:2]            addr_w;
  logic                   dec_valid;
  logic [REG_IDX_W-1:0]   dec_idx;
  logic [N_REGION-1:0]    dec_onehot;
  logic                   ack_hit;
  logic [31:0]            sel_rdata;
`ifdef EPC_BUS_CTL_TIMEOUT_EN
  logic [3:0]             tmo_cnt;
`endif

  assign addr_w = 30'(epc_to_le(epc_addr) >> 2);

  epc_decode #(.N_REGION(N_REGION)) u_decode (
    .addr   (addr_w[31:REG_IDX_LSB]),
    .valid  (dec_valid),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  // Only the selected region's ack counts; strays from other regions are masked off
  assign ack_hit = |(reg_ack & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REGION; i++)
      if (i == 32'(idx_q)) sel_rdata = reg_rdata[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rnw_q      <= 1'b0;
      idx_q      <= '0;
      sel_q      <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_be     <= '0;
      reg_wr_stb <= '0;
      reg_rd_stb <= '0;
      epc_rdy    <= 1'b0;
      epc_rdata  <= '0;
      err_cnt    <= '0;
`ifdef EPC_BUS_CTL_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      reg_wr_stb <= '0;
      reg_rd_stb <= '0;
      epc_rdy    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (epc_ads && !epc_cs_n) begin
            rnw_q     <= epc_rnw;
            idx_q     <= dec_idx;
            sel_q     <= dec_onehot;
            reg_addr  <= addr_w[7:2];
            reg_wdata <= epc_to_le(epc_wdata);
            reg_be    <= epc_be;
`ifdef EPC_BUS_CTL_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            if (!dec_valid) begin
              state     <= ST_DONE;
              epc_rdy   <= 1'b1;
              epc_rdata <= epc_rnw ? ERR_WORD : 32'd0;
              err_cnt   <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            end else begin
              state <= ST_ISSUE;
              if (epc_rnw) reg_rd_stb <= dec_onehot;
              else         reg_wr_stb <= dec_onehot;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (epc_cs_n) begin
            state <= ST_IDLE;
          end else if (ack_hit) begin
            state     <= ST_DONE;
            epc_rdy   <= 1'b1;
            epc_rdata <= rnw_q ? sel_rdata : 32'd0;
          end else begin
`ifdef EPC_BUS_CTL_TIMEOUT_EN
            if (state == ST_WAIT && tmo_cnt == 4'(TIMEOUT)) begin
              state     <= ST_DONE;
              epc_rdy   <= 1'b1;
              epc_rdata <= rnw_q ? ERR_WORD : 32'd0;
              err_cnt   <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            end else begin
              state   <= ST_WAIT;
              tmo_cnt <= tmo_cnt + 4'd1;
            end
`else
            state <= ST_WAIT;
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/epc_bus_ctl.md
# epc_bus_ctl

EPC slave-side bus controller between the PS External Peripheral Controller (EPC) interface and the fabric register blocks. It accepts one single-beat EPC transaction at a time, decodes the address to one of N register regions, and issues a one-cycle read or write strobe on a shared register bus. It then waits for that region's acknowledge and returns `epc_rdy` with read data. Bad addresses and unacknowledged accesses end with an error word, so the PS never hangs.

## Interface
Parameters:
- `N_REGION`, 32: number of register regions; region index is `addr[15:8]`.
- `TIMEOUT`, 8: cycles to wait for `reg_ack` after the strobe; must be ≤ 8 so `epc_rdy` arrives within 10 cycles of `ads`.
- `ERR_WORD`, 32'hDEADBEEF: read data returned on error or timeout.

Ports (EPC buses use `[0:31]` ordering; bit 0 is the MSB):
- `clk`  in  1  OCXO 100 MHz clock.
- `rst_n`  in  1  reset, active-low.
- `epc_addr`  in  [0:31]  EPC address; sampled when `ads` is high.
- `epc_ads`  in  1  address strobe, one-cycle pulse.
- `epc_cs_n`  in  1  chip select, active-low.
- `epc_rnw`  in  1  1 = read, 0 = write.
- `epc_be`  in  [0:3]  byte enables.
- `epc_wdata`  in  [0:31]  write data from the PS.
- `epc_rdata`  out  [0:31]  read data to the PS.
- `epc_rdy`  out  1  transfer complete, one-cycle pulse.
- `reg_addr`  out  6  word offset, `addr[7:2]`.
- `reg_wdata`  out  32  registered write data.
- `reg_be`  out  4  registered byte enables.
- `reg_wr_stb`  out  N_REGION  one-hot write strobe.
- `reg_rd_stb`  out  N_REGION  one-hot read strobe.
- `reg_rdata`  in  N_REGION*32  per-region read data, packed.
- `reg_ack`  in  N_REGION  per-region acknowledge.
- `err_cnt`  out  16  count of error and timeout transactions; saturates.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If `epc_ads` & !`epc_cs_n`: capture addr, be, wdata and rnw.
  - If `addr[31:16]` ≠ 0 or `addr[15:8]` ≥ N_REGION: go to DONE as an error.
  - Otherwise go to ISSUE.
- ISSUE: assert `reg_rd_stb[idx]` or `reg_wr_stb[idx]` for exactly one cycle, then go to WAIT.
- WAIT: on `reg_ack[idx]`, register `reg_rdata[idx]` (reads only) and go to DONE.
  - With timeout enabled: counter expiry sets the error and goes to DONE.
  - Acks from unselected regions are ignored.
- DONE: `epc_rdy` = 1 for one cycle; `epc_rdata` = data (reads), `ERR_WORD` (read error), or 0 (writes). Then go to IDLE.
- Errors increment `err_cnt`; it saturates at 16'hFFFF.
- Abort: `epc_cs_n` high in ISSUE or WAIT → go to IDLE with no `epc_rdy`; a late ack is ignored.
- `epc_ads` outside IDLE is ignored and does not queue.
- A write of `be` = 0 is still issued; `be` is passed through.

## Timing
- Reset values:
  - all strobes 0, `epc_rdy` 0, `epc_rdata` 0, `reg_*` outputs 0, `err_cnt` 0, FSM IDLE, timeout counter 0.
  - Reset mid-transaction drops it silently.
- `ads` sampled at edge 0 → strobe during cycle 1 → earliest ack sampled at the end of cycle 1 → `epc_rdy` in cycle 2.
- Address error: `epc_rdy` in cycle 1.
- Timeout: the counter starts in ISSUE; with no ack by WAIT cycle TIMEOUT, `epc_rdy` comes at cycle TIMEOUT+2.
- `epc_rdata` is valid only while `epc_rdy` = 1 and holds until the next DONE.
- Ack and timeout in the same cycle: the ack wins and no error is counted.

## Configuration
- `EPC_BUS_CTL_TIMEOUT_EN` defined: WAIT times out as above.
- Undefined: the timeout counter is removed; WAIT lasts until ack or abort. Address errors still return `ERR_WORD` immediately.

## Structure
- In `epc_pkg`:
  - FSM state enum;
  - `EPC_ERR_WORD`;
  - the region-index field constants (`REG_IDX_MSB`=15, `REG_IDX_LSB`=8);
  - a function that converts `[0:31]` to `[31:0]`.
- Sub-module `epc_decode`: combinational address → {valid, idx, one-hot}; reused by future bus bridges.

## Test plan
- Write 0x200 data 0x00000080; region 2 acks in cycle 1:
  - `reg_wr_stb[2]` pulses once with `reg_addr` 0, `reg_wdata` 0x80 and `reg_be` 0xF;
  - `epc_rdy` comes 2 cycles after `ads`.
- Read 0x1830; region 24 acks after 3 cycles with 0xCAFE0001: `reg_addr` = 0x0C; `epc_rdy` at cycle 5 with `epc_rdata` 0xCAFE0001.
- Read 0xA5A5A5A5: no strobe; `epc_rdy` at cycle 1 with 0xDEADBEEF; `err_cnt` = 1.
- Read 0x100 with region 1 never acking (`TIMEOUT`=8, macro on): `epc_rdy` at cycle 10 with 0xDEADBEEF; `err_cnt` increments.
- Read 0x300; `cs_n` rises in WAIT cycle 2, then ack in cycle 4: no `epc_rdy`; FSM in IDLE; the next access to 0x100 completes normally.
- `rst_n` low during WAIT: all outputs return to reset values; with a new `ads` after release, the first transaction completes in 2 cycles.
